genramrec: RTL and testbench

//  Timed pattern recorder: the writer counterpart of the ROM-driven LED sequencer.

---
 rtl/genramrec_pkg.sv | 15 +
 rtl/genramrec_genram.sv | 31 +++
 rtl/genramrec.sv | 105 ++++++++++
 tb/tb_genramrec.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/genramrec_pkg.sv
// Shared definitions for the pattern recorder: FSM encodings and the default
// bus geometry used by the recorder and its player/sequencer.
package genramrec_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REC  = 2'd1,
      ST_FULL = 2'd2
   } state_t;

   localparam int DEF_DW    = 5;
   localparam int DEF_AW    = 5;
   localparam int DEF_DELAY = 2;

endpackage

// File: rtl/genramrec_genram.sv
// Generic RAM: one write port, one registered read port (read-before-write).
// Contents are left uninitialised; RAMFILE is accepted for interface compatibility.
module genram
   import genramrec_pkg::*;
#(
   parameter int    DW      = DEF_DW,
   parameter int    AW      = DEF_AW,
   parameter string RAMFILE = ""
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   // Reset clears only the output register; stored words survive a reset.
   always_ff @(posedge clk) begin
      if (rst) rd_data <= '0;
      else     rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/genramrec.sv
// Timed pattern recorder: samples din every 2^DELAY clocks into a RAM.
// Build option RECORDER_LOOP_EN: circular recording instead of halting when full.
//
// state | meaning
// IDLE  | not recording; len/RAM hold the last take
// REC   | recording, one sample per prescaler wrap
// FULL  | all 2^AW words written, recording halted
module genramrec
   import genramrec_pkg::*;
#(
   parameter int    DW      = DEF_DW,
   parameter int    AW      = DEF_AW,
   parameter int    DELAY   = DEF_DELAY,
   parameter string RAMFILE = ""
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stop,
   input  logic [DW-1:0] din,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic          busy,
   output logic          full,
   output logic [AW:0]   len
);

   localparam int              PW    = (DELAY > 0) ? DELAY : 1;
   localparam logic [PW-1:0]   PMAX  = PW'((1 << DELAY) - 1);
   localparam logic [AW:0]     DEPTH = {1'b1, {AW{1'b0}}};
   localparam logic [AW-1:0]   LAST  = '1;

   state_t        state, state_nxt;
   logic [PW-1:0] presc;
   logic [AW-1:0] addr;
   logic [AW:0]   len_q;
   logic          full_q;
   logic          tick, we, restart;

   always_comb begin
      state_nxt = state;
      we        = 1'b0;
      restart   = 1'b0;
      tick      = (presc == '0);
      case (state)
         ST_IDLE, ST_FULL: begin
            if (start && !stop) begin
               state_nxt = ST_REC;
               restart   = 1'b1;
            end
         end
         ST_REC: begin
            we = tick;
            if (stop) state_nxt = ST_IDLE;
`ifdef RECORDER_LOOP_EN
            else if (tick && addr == LAST) state_nxt = ST_REC;
`else
            else if (tick && addr == LAST) state_nxt = ST_FULL;
`endif
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // len saturates so a looping take never wraps past 2^AW.
   always_ff @(posedge clk) begin
      if (rst || restart) begin
         presc  <= '0;
         addr   <= '0;
         len_q  <= '0;
         full_q <= 1'b0;
      end else if (state == ST_REC) begin
         presc <= (presc == PMAX) ? '0 : presc + 1'b1;
         if (we) begin
            addr <= addr + 1'b1;
            if (len_q != DEPTH) len_q <= len_q + 1'b1;
            if (addr == LAST)   full_q <= 1'b1;
         end
      end
   end

   genram #(
      .DW     (DW),
      .AW     (AW),
      .RAMFILE(RAMFILE)
   ) u_ram (
      .clk    (clk),
      .rst    (rst),
      .we     (we & ~rst),
      .wr_addr(addr),
      .wr_data(din),
      .rd_addr(rd_addr),
      .rd_data(rd_data)
   );

   assign busy = (state == ST_REC);
   assign full = full_q;
   assign len  = len_q;

endmodule

// File: tb/tb_genramrec.sv
// Bench for genramrec: directed takes plus random traffic against a
// sample-count reference model; read data checked through a scoreboard queue.
module tb_genramrec;

   localparam int DW = 5, AW = 3, DELAY = 2;
   localparam int DEPTH = 8, PER = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1, start = 1'b0, stop = 1'b0;
   logic [DW-1:0] din = '0;
   logic [AW-1:0] rd_addr = '0;
   logic [DW-1:0] rd_data;
   logic          busy, full;
   logic [AW:0]   len;

   logic          rd_en = 1'b0, rd_vld = 1'b0;
   int            vectors = 0, miscompares = 0;
   logic [DW-1:0] exp_q[$];

   // Reference model: a take is a count of REC cycles; every PER-th cycle stores a sample.
   bit            m_rec = 0, m_full = 0;
   int            m_len = 0, m_wr = 0, m_cnt = 0;
   logic [DW-1:0] m_mem[DEPTH];
   bit            m_valid[DEPTH];

   genramrec #(.DW(DW), .AW(AW), .DELAY(DELAY), .RAMFILE("")) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .stop   (stop),
      .din    (din),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .busy   (busy),
      .full   (full),
      .len    (len)
   );

   always #1 clk = ~clk;

   always @(posedge clk) rd_vld <= rd_en;

   always @(negedge clk) begin
      if (rd_vld) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL rd_data: got %h with no expected entry", rd_data);
         end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (rd_data !== e) begin
               miscompares++;
               $display("FAIL rd_data: got %h expected %h", rd_data, e);
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   task automatic model_edge(input bit r, input bit s, input bit p, input logic [DW-1:0] d);
      if (r) begin
         m_rec = 0; m_full = 0; m_len = 0;
      end else if (!m_rec) begin
         if (s && !p) begin
            m_rec = 1; m_full = 0; m_len = 0; m_wr = 0; m_cnt = 0;
         end
      end else begin
         if (m_cnt % PER == 0) begin
            m_mem[m_wr % DEPTH]   = d;
            m_valid[m_wr % DEPTH] = 1;
            m_wr++;
            m_len = (m_wr < DEPTH) ? m_wr : DEPTH;
            if (m_wr >= DEPTH) m_full = 1;
`ifndef RECORDER_LOOP_EN
            if (m_wr == DEPTH) m_rec = 0;
`endif
         end
         m_cnt++;
         if (p) m_rec = 0;
      end
   endtask

   // Drive one cycle: inputs at negedge, model the coming edge, check status at next negedge.
   task automatic cyc(input bit r, input bit s, input bit p, input logic [DW-1:0] d, input int ra);
      bit re;
      rst = r; start = s; stop = p; din = d;
      rd_addr = ra[AW-1:0];
      re = r || m_valid[ra];
      rd_en = re;
      if (re) exp_q.push_back(r ? '0 : m_mem[ra]);
      model_edge(r, s, p, d);
      @(posedge clk);
      @(negedge clk);
      check("busy", 32'(busy), 32'(m_rec));
      check("full", 32'(full), 32'(m_full));
      check("len",  32'(len),  32'(m_len));
   endtask

   task automatic rnd_cyc(input bit s, input bit p);
      cyc(0, s, p, DW'($urandom), int'($urandom_range(0, DEPTH - 1)));
   endtask

   task automatic read_all();
      for (int a = 0; a < DEPTH; a++) cyc(0, 0, 0, '0, a);
   endtask

   initial begin
      logic [DW-1:0] pat[8];
      pat[0] = 5'h01; pat[1] = 5'h02; pat[2] = 5'h04; pat[3] = 5'h08;
      pat[4] = 5'h10; pat[5] = 5'h01; pat[6] = 5'h02; pat[7] = 5'h04;

      @(negedge clk);
      cyc(1, 0, 0, '0, 0);
      cyc(1, 0, 0, '0, 0);
      check("reset rd_data", 32'(rd_data), 32'd0);

      // Full take of the walking pattern, then replay.
      cyc(0, 1, 0, '0, 0);
      for (int k = 0; k < 32; k++) cyc(0, 0, 0, pat[k / PER], k % DEPTH);
      check("full after take", 32'(full), 32'd1);
      read_all();

      // Early stop after 10 REC cycles.
      cyc(0, 1, 0, '0, 0);
      for (int k = 0; k < 9; k++) rnd_cyc(0, 0);
      rnd_cyc(0, 1);
      check("len after early stop", 32'(len), 32'd3);
      read_all();

      // Stop coinciding with the third write tick.
      cyc(0, 1, 0, '0, 0);
      for (int k = 0; k < 8; k++) rnd_cyc(0, 0);
      cyc(0, 0, 1, 5'h1F, 2);
      cyc(0, 0, 0, '0, 2);

      // Reset in the middle of a take.
      cyc(0, 1, 0, '0, 0);
      for (int k = 0; k < 6; k++) rnd_cyc(0, 0);
      cyc(1, 0, 0, DW'($urandom), 0);
      cyc(0, 0, 0, '0, 0);
      cyc(0, 0, 0, '0, 1);

      // Long take: 12 ticks then stop (wraps in loop builds).
      cyc(0, 1, 0, '0, 0);
      for (int k = 0; k < 45; k++) rnd_cyc(0, 0);
      rnd_cyc(0, 1);
      read_all();

      // Start and stop together never begin a take; start while recording is ignored.
      cyc(0, 1, 1, '0, 0);
      cyc(0, 1, 0, '0, 0);
      for (int k = 0; k < 6; k++) rnd_cyc(1, 0);
      rnd_cyc(0, 1);

      for (int k = 0; k < 400; k++)
         if ($urandom_range(0, 99) == 0) cyc(1, 0, 0, DW'($urandom), int'($urandom_range(0, DEPTH - 1)));
         else rnd_cyc($urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0);

      read_all();
      rd_en = 1'b0;
      repeat (2) @(negedge clk);
      check("scoreboard drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
